// File: rtl/ulight_fifo_pkg.sv
// Shared constants for the uLight SpaceWire TX write path:
// register map, STATUS bit positions and TX state encodings.
package ulight_fifo_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_PKTCNT  = 2'd3;

    localparam int ST_LEVEL_LSB  = 0;
    localparam int ST_LEVEL_MSB  = 4;
    localparam int ST_EMPTY_BIT  = 5;
    localparam int ST_FULL_BIT   = 6;
    localparam int ST_OVF_BIT    = 7;
    localparam int ST_FFULL_BIT  = 8;
    localparam int ST_STATE_LSB  = 9;
    localparam int ST_STATE_MSB  = 10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    // Control flag in the SpaceWire word: set on EOP/EEP markers.
    localparam int EOP_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } tx_state_e;

endpackage

// File: rtl/ulight_fifo_tx_write_ctrl_if.sv
// Avalon-MM slave bus plus the TX FIFO write side, bundled for the controller.
interface ulight_fifo_tx_write_ctrl_if #(
    parameter int WIDTH = 9
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] fifo_wr_data;
    logic             fifo_wr_en;
    logic             fifo_full;

    // Controller side.
    modport slave (
        input  address, chipselect, write_n, writedata, fifo_full,
        output readdata, fifo_wr_data, fifo_wr_en
    );

    // CPU / FIFO side driving the controller.
    modport master (
        output address, chipselect, write_n, writedata, fifo_full,
        input  readdata, fifo_wr_data, fifo_wr_en
    );
endinterface

// File: rtl/ulight_fifo_tx_stage_queue.sv
// Small circular staging queue between the CPU and the TX FIFO.
// A push into a full queue is only taken when a pop frees a slot the same cycle.
module ulight_fifo_tx_stage_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             accepted,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign accepted = push && !flush && (!full || pop);
    assign head     = mem[rd_ptr];

    // Storage and pointers; storage is cleared on reset so the head reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accepted) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(accepted) - LW'(pop);
        end
    end

endmodule

// File: rtl/ulight_fifo_tx_write_ctrl.sv
// CPU-facing write controller: stages words written over Avalon-MM and
// streams them into the SpaceWire TX FIFO one per cycle when enabled.
module ulight_fifo_tx_write_ctrl
    import ulight_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ulight_fifo_tx_write_ctrl_if.slave    bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic             wr, data_wr, status_wr, ctrl_wr, pkt_wr;
    logic             flush, pop, accepted, ovf_set;
    logic             enable, enable_next, overflow;
    logic [15:0]      pktcnt;
    logic [WIDTH-1:0] head;
    logic [LW-1:0]    level, level_next;
    logic             full, empty;
    logic [31:0]      rdata;
    logic             unused_wdata;
    tx_state_e        state_q, state_next;

    assign wr        = bus.chipselect && !bus.write_n;
    assign data_wr   = wr && (bus.address == ADDR_DATA);
    assign status_wr = wr && (bus.address == ADDR_STATUS);
    assign ctrl_wr   = wr && (bus.address == ADDR_CONTROL);
    assign pkt_wr    = wr && (bus.address == ADDR_PKTCNT);
    assign flush     = ctrl_wr && bus.writedata[CTRL_FLUSH_BIT];

    assign pop     = enable && !empty && !bus.fifo_full;
    assign ovf_set = data_wr && !accepted;

    assign bus.fifo_wr_en   = pop;
    assign bus.fifo_wr_data = head;
    assign bus.readdata     = rdata;
    assign unused_wdata     = ^bus.writedata[31:WIDTH];

    ulight_fifo_tx_stage_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (data_wr),
        .push_data (bus.writedata[WIDTH-1:0]),
        .pop       (pop),
        .flush     (flush),
        .accepted  (accepted),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // Register-side state: enable, sticky overflow (set beats clear), packet count (clear beats increment).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
            pktcnt   <= '0;
        end else begin
            if (ctrl_wr) enable <= bus.writedata[CTRL_ENABLE_BIT];
            if (ovf_set) overflow <= 1'b1;
            else if (status_wr && bus.writedata[ST_OVF_BIT]) overflow <= 1'b0;
            if (pkt_wr) pktcnt <= '0;
            else if (pop && head[EOP_BIT]) pktcnt <= pktcnt + 16'd1;
        end
    end

    // Look-ahead of enable/level so the state register tracks the coming cycle.
    always_comb begin
        enable_next = ctrl_wr ? bus.writedata[CTRL_ENABLE_BIT] : enable;
        level_next  = flush ? '0 : level + LW'(accepted) - LW'(pop);
    end

    // TX state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_next;
    end

    // Next state: idle unless enabled with words pending, then send or stall on FIFO full.
    always_comb begin
        state_next = ST_IDLE;
        if (enable_next && (level_next != '0))
            state_next = bus.fifo_full ? ST_STALL : ST_SEND;
    end

    // Zero-wait-state read mux.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:    rdata[WIDTH-1:0] = head;
            ADDR_STATUS: begin
                rdata[ST_LEVEL_MSB:ST_LEVEL_LSB] = 5'(level);
                rdata[ST_EMPTY_BIT]              = empty;
                rdata[ST_FULL_BIT]               = full;
                rdata[ST_OVF_BIT]                = overflow;
                rdata[ST_FFULL_BIT]              = bus.fifo_full;
                rdata[ST_STATE_MSB:ST_STATE_LSB] = state_q;
            end
            ADDR_CONTROL: rdata[CTRL_ENABLE_BIT] = enable;
            ADDR_PKTCNT:  rdata[15:0] = pktcnt;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ulight_fifo_tx_write_ctrl.sv
// Bench for the uLight TX write controller: register vectors from a table,
// then hand-written sequences for streaming, overflow, stall, wrap and reset.
`timescale 1ns/1ps
module tb_ulight_fifo_tx_write_ctrl;
    import ulight_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ulight_fifo_tx_write_ctrl_if #(.WIDTH(WIDTH)) bus();

    ulight_fifo_tx_write_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [1:0] wa, logic [31:0] wd, logic [1:0] ra,
                                logic [31:0] e, string n);
        vec_t v;
        v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = e; v.name = n;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must carry the oldest expected word.
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            if (strobe_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            strobe_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got data 0x%0h, no word expected", bus.fifo_wr_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                if (bus.fifo_wr_data !== e) begin
                    errors++;
                    $display("FAIL strobe_data: got 0x%0h, expected 0x%0h", bus.fifo_wr_data, e);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(logic [1:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(string name, int maxc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < maxc) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words still pending after %0d cycles, expected 0", name, sb.size(), k);
        end
    endtask

    initial begin
        logic [31:0] r;

        vecs[0]  = mk(ADDR_CONTROL, 32'h1,        ADDR_CONTROL, 32'h1,   "ctrl_enable");
        vecs[1]  = mk(ADDR_CONTROL, 32'h3,        ADDR_CONTROL, 32'h1,   "ctrl_flush_reads0");
        vecs[2]  = mk(ADDR_CONTROL, 32'h0,        ADDR_CONTROL, 32'h0,   "ctrl_disable");
        vecs[3]  = mk(ADDR_CONTROL, 32'hFFFFFFFC, ADDR_CONTROL, 32'h0,   "ctrl_upper_bits");
        vecs[4]  = mk(ADDR_PKTCNT,  32'h1234,     ADDR_PKTCNT,  32'h0,   "pktcnt_clear");
        vecs[5]  = mk(ADDR_STATUS,  32'hFFFFFFFF, ADDR_STATUS,  32'h020, "status_empty");
        vecs[6]  = mk(ADDR_DATA,    32'hFFFFF1AB, ADDR_DATA,    32'h1AB, "data_head_zext");
        vecs[7]  = mk(ADDR_DATA,    32'h055,      ADDR_STATUS,  32'h002, "status_level2");
        vecs[8]  = mk(ADDR_DATA,    32'h0CD,      ADDR_DATA,    32'h1AB, "head_kept");
        vecs[9]  = mk(ADDR_CONTROL, 32'h2,        ADDR_STATUS,  32'h020, "flush_empties");
        vecs[10] = mk(ADDR_DATA,    32'h077,      ADDR_STATUS,  32'h001, "status_level1");
        vecs[11] = mk(ADDR_CONTROL, 32'h2,        ADDR_STATUS,  32'h020, "flush_again");
        vecs[12] = mk(ADDR_CONTROL, 32'h0,        ADDR_PKTCNT,  32'h0,   "pktcnt_idle");

        bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0;
        bus.write_n = 1'b1; bus.fifo_full = 1'b0;

        // Reset state
        wait_cycles(3);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("rst_wr_data", 32'(bus.fifo_wr_data), 32'h0);
        reset_n = 1'b1;
        rd(ADDR_STATUS, r);  check("rst_status", r, 32'h020);
        rd(ADDR_CONTROL, r); check("rst_control", r, 32'h0);
        rd(ADDR_PKTCNT, r);  check("rst_pktcnt", r, 32'h0);

        // Register vectors (queue never enabled while non-empty here)
        for (int i = 0; i < NV; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            idle();
            rd(vecs[i].raddr, r);
            check(vecs[i].name, r, vecs[i].exp);
        end

        // Streaming: three words on three consecutive cycles, one EOP
        wr(ADDR_CONTROL, 32'h1);
        strobe_cnt = 0;
        wr(ADDR_DATA, 32'h041); sb.push_back(9'h041);
        wr(ADDR_DATA, 32'h042); sb.push_back(9'h042);
        wr(ADDR_DATA, 32'h100); sb.push_back(9'h100);
        idle();
        drain("stream_drain", 20);
        check("stream_strobes", 32'(strobe_cnt), 32'd3);
        check("stream_consecutive", 32'(last_cyc - first_cyc), 32'd2);
        rd(ADDR_PKTCNT, r); check("stream_pktcnt", r, 32'h1);

        // Overflow: fifth word dropped, sticky flag cleared by W1C
        wr(ADDR_CONTROL, 32'h0);
        for (int i = 0; i < 5; i++) begin
            wr(ADDR_DATA, 32'h010 + 32'(i));
            if (i < 4) sb.push_back(9'(9'h010 + 9'(i)));
        end
        idle();
        rd(ADDR_STATUS, r); check("ovf_status", r, 32'h0C4);
        wr(ADDR_STATUS, 32'h80);
        idle();
        rd(ADDR_STATUS, r); check("ovf_cleared", r, 32'h044);

        // Full queue: push in the same cycle as a pop is accepted
        strobe_cnt = 0;
        wr(ADDR_CONTROL, 32'h1);
        wr(ADDR_DATA, 32'h1FF); sb.push_back(9'h1FF);
        idle();
        rd(ADDR_STATUS, r); check("full_push_pop", r, 32'h244);
        drain("full_drain", 20);
        check("full_strobes", 32'(strobe_cnt), 32'd5);
        rd(ADDR_STATUS, r); check("full_after", r, 32'h020);

        // Stall: downstream full for 10 cycles, then release
        wr(ADDR_CONTROL, 32'h0);
        bus.fifo_full = 1'b1;
        wr(ADDR_DATA, 32'h031); sb.push_back(9'h031);
        wr(ADDR_DATA, 32'h032); sb.push_back(9'h032);
        wr(ADDR_DATA, 32'h133); sb.push_back(9'h133);
        wr(ADDR_CONTROL, 32'h1);
        idle();
        strobe_cnt = 0;
        wait_cycles(10);
        check("stall_no_strobe", 32'(strobe_cnt), 32'd0);
        rd(ADDR_STATUS, r); check("stall_status", r, 32'h503);
        bus.fifo_full = 1'b0;
        drain("stall_drain", 20);
        check("stall_strobes", 32'(strobe_cnt), 32'd3);

        // Packet counter wrap and clear-beats-increment
        wr(ADDR_PKTCNT, 32'h0);
        for (int i = 0; i < 65535; i++) begin
            wr(ADDR_DATA, 32'h100); sb.push_back(9'h100);
        end
        idle();
        drain("wrap_drain", 20);
        rd(ADDR_PKTCNT, r); check("pktcnt_ffff", r, 32'hFFFF);
        wr(ADDR_DATA, 32'h100); sb.push_back(9'h100);
        idle();
        drain("wrap_drain2", 20);
        rd(ADDR_PKTCNT, r); check("pktcnt_wrap", r, 32'h0);
        wr(ADDR_DATA, 32'h100); sb.push_back(9'h100);
        wr(ADDR_PKTCNT, 32'h0);
        idle();
        drain("clr_drain", 20);
        rd(ADDR_PKTCNT, r); check("pktcnt_clear_wins", r, 32'h0);

        // Reset while streaming two words
        wr(ADDR_DATA, 32'h0A1);
        wr(ADDR_DATA, 32'h0A2);
        check("rst_pre_strobe", 32'(bus.fifo_wr_en), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("rst_async_data", 32'(bus.fifo_wr_data), 32'h0);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        wait_cycles(2);
        check("rst_hold_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        reset_n = 1'b1;
        rd(ADDR_STATUS, r); check("rst_release_status", r, 32'h020);
        bus.address = ADDR_DATA; bus.writedata = 32'h0C3;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        idle();
        rd(ADDR_STATUS, r); check("rst_first_write", r, 32'h001);
        rd(ADDR_DATA, r);   check("rst_first_head", r, 32'h0C3);

        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
